core_lsu: RTL and testbench

Load/store unit between the core's execute stage and the word-addressed data memory (`mem`). It accepts one RV32I load or store per handshake and produces aligned 32-bit memory reads and writes. It performs byte/halfword lane selection and sign/zero extension for loads. Because the memory has no byte enables, sub-word stores are built by read-modify-write. It also detects illegal and misaligned accesses.

---
 rtl/core_lsu.sv | 136 +++++++++++++
 tb/tb_core_lsu.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/core_lsu.sv
// core_lsu: RV32I load/store unit, sub-word stores via read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses.
module core_lsu #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err,
   output logic                  mem_rd,
   output logic                  mem_wr,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata
);

   typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

   state_t                state_q, state_d;
   logic                  we_q, err_q;
   logic [2:0]            f3_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q, word_q;
   logic                  accept, illegal, misalign;
   logic [31:0]           merged, ext;
   logic [7:0]            byte_v;
   logic [15:0]           half_v;

   assign req_ready = (state_q == IDLE);
   assign accept    = req_valid && req_ready;

   assign illegal = req_we ? (req_funct3 > 3'b010)
                           : (req_funct3 == 3'b011 ||
                              req_funct3[2:1] == 2'b11);

`ifdef LSU_MISALIGN_TRAP_EN
   always_comb begin
      misalign = 1'b0;
      unique case (req_funct3[1:0])
         2'b01:   misalign = req_addr[0];
         2'b10:   misalign = |req_addr[1:0];
         default: misalign = 1'b0;
      endcase
   end
`else
   assign misalign = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q    <= req_we;
            err_q   <= illegal || misalign;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if (state_q == WAIT)
            word_q <= mem_rdata;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (illegal || misalign)
                  state_d = RESP;
               else if (req_we && req_funct3[1:0] == 2'b10)
                  state_d = WR;
               else
                  state_d = RD;
            end
         end
         RD:      state_d = WAIT;
         WAIT:    state_d = we_q ? WR : RESP;
         WR:      state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Store word: untouched lanes come from the word read in WAIT.
   always_comb begin
      merged = word_q;
      unique case (f3_q[1:0])
         2'b10: merged = wdata_q;
         2'b01: begin
            if (addr_q[1])
               merged[31:16] = wdata_q[15:0];
            else
               merged[15:0] = wdata_q[15:0];
         end
         default: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      endcase
   end

   always_comb begin
      byte_v = word_q[{addr_q[1:0], 3'b000} +: 8];
      half_v = addr_q[1] ? word_q[31:16] : word_q[15:0];
      ext    = word_q;
      unique case (f3_q[1:0])
         2'b00:   ext = {{24{byte_v[7] & ~f3_q[2]}}, byte_v};
         2'b01:   ext = {{16{half_v[15] & ~f3_q[2]}}, half_v};
         default: ext = word_q;
      endcase
   end

   assign mem_rd    = (state_q == RD) && !rst;
   assign mem_wr    = (state_q == WR) && !rst;
   assign mem_addr  = (mem_rd || mem_wr) ?
                      {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
   assign mem_wdata = mem_wr ? merged : '0;

   assign resp_valid = (state_q == RESP) && !rst;
   assign resp_err   = resp_valid && err_q;
   assign resp_rdata = (resp_valid && !we_q && !err_q) ? ext : '0;

endmodule

// File: tb/tb_core_lsu.sv
// tb_core_lsu: directed checks of core_lsu against a small word memory.
// Expected values are hand-computed per vector.
module tb_core_lsu;

   logic        clk = 1'b0;
   logic        rst, req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err, mem_rd, mem_wr;
   logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [31:0] mem [0:63];
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   core_lsu #(.ADDR_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err),
      .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always @(posedge clk) begin
      if (mem_rd) mem_rdata <= mem[mem_addr[7:2]];
      if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Issue one request, watch up to 8 cycles, check event cycles/data.
   task automatic op(input string tag, input logic we,
                     input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input int e_rd,
                     input int e_wr, input int e_rv,
                     input logic [31:0] e_rdata, input logic e_err,
                     input logic [31:0] e_wdata);
      int rd_c, wr_c, rv_c, rdy_bad, both;
      logic [31:0] wdat, waddr, rdat;
      logic err;
      rd_c = -1; wr_c = -1; rv_c = -1; rdy_bad = 0; both = 0;
      wdat = '0; waddr = '0; rdat = '0; err = 1'b0;
      req_valid = 1'b1; req_we = we; req_funct3 = f3;
      req_addr = addr; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         if (mem_rd && rd_c < 0) rd_c = c;
         if (mem_wr && wr_c < 0) begin
            wr_c = c; wdat = mem_wdata; waddr = mem_addr;
         end
         if (mem_rd && mem_wr) both++;
         if (req_ready) rdy_bad++;
         if (resp_valid) begin
            rv_c = c; rdat = resp_rdata; err = resp_err;
            break;
         end
         @(posedge clk); #1;
      end
      chk({tag, ".rd_cyc"}, 32'(rd_c), 32'(e_rd));
      chk({tag, ".wr_cyc"}, 32'(wr_c), 32'(e_wr));
      chk({tag, ".resp_cyc"}, 32'(rv_c), 32'(e_rv));
      chk({tag, ".rdata"}, rdat, e_rdata);
      chk({tag, ".err"}, 32'(err), 32'(e_err));
      chk({tag, ".busy_ready"}, 32'(rdy_bad), 32'd0);
      chk({tag, ".rd_wr_both"}, 32'(both), 32'd0);
      if (e_wr > 0) begin
         chk({tag, ".wdata"}, wdat, e_wdata);
         chk({tag, ".waddr"}, waddr, {addr[31:2], 2'b00});
      end
      @(posedge clk); #1;
      chk({tag, ".ready_after"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] vals [5];
      int seen;
      vals = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3};
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
      req_funct3 = '0; req_addr = '0; req_wdata = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst.ready", 32'(req_ready), 32'd1);
      chk("rst.resp_valid", 32'(resp_valid), 32'd0);
      chk("rst.resp_err", 32'(resp_err), 32'd0);
      chk("rst.mem_rd", 32'(mem_rd), 32'd0);
      chk("rst.mem_wr", 32'(mem_wr), 32'd0);
      chk("rst.resp_rdata", resp_rdata, 32'd0);
      chk("rst.mem_addr", mem_addr, 32'd0);
      chk("rst.mem_wdata", mem_wdata, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Loads with extension from word 0x8000F0FF
      op("sw80", 1, 3'b010, 32'h80, 32'h8000F0FF,
         -1, 1, 2, 32'h0, 0, 32'h8000F0FF);
      op("lb80", 0, 3'b000, 32'h80, 32'h0,
         1, -1, 3, 32'hFFFFFFFF, 0, 32'h0);
      op("lbu81", 0, 3'b100, 32'h81, 32'h0,
         1, -1, 3, 32'h000000F0, 0, 32'h0);
      op("lh82", 0, 3'b001, 32'h82, 32'h0,
         1, -1, 3, 32'hFFFF8000, 0, 32'h0);
      op("lhu82", 0, 3'b101, 32'h82, 32'h0,
         1, -1, 3, 32'h00008000, 0, 32'h0);
      op("lw80", 0, 3'b010, 32'h80, 32'h0,
         1, -1, 3, 32'h8000F0FF, 0, 32'h0);

      // Sub-word stores
      op("sw84", 1, 3'b010, 32'h84, 32'h11223344,
         -1, 1, 2, 32'h0, 0, 32'h11223344);
      op("sb85", 1, 3'b000, 32'h85, 32'h000000AB,
         1, 3, 4, 32'h0, 0, 32'h1122AB44);
      op("sh86", 1, 3'b001, 32'h86, 32'h0000BEEF,
         1, 3, 4, 32'h0, 0, 32'hBEEFAB44);
      op("lw84", 0, 3'b010, 32'h84, 32'h0,
         1, -1, 3, 32'hBEEFAB44, 0, 32'h0);
      op("sw88", 1, 3'b010, 32'h88, 32'h00000005,
         -1, 1, 2, 32'h0, 0, 32'h00000005);
      op("lw88", 0, 3'b010, 32'h88, 32'h0,
         1, -1, 3, 32'h00000005, 0, 32'h0);

      for (int i = 0; i < 5; i++)
         op($sformatf("swv%0d", i), 1, 3'b010, 32'h80 + 32'(4*i),
            vals[i], -1, 1, 2, 32'h0, 0, vals[i]);
      for (int i = 0; i < 5; i++)
         op($sformatf("lwv%0d", i), 0, 3'b010, 32'h80 + 32'(4*i),
            32'h0, 1, -1, 3, vals[i], 0, 32'h0);

`ifdef LSU_MISALIGN_TRAP_EN
      op("lw86", 0, 3'b010, 32'h86, 32'h0,
         -1, -1, 1, 32'h0, 1, 32'h0);
`else
      op("lw86", 0, 3'b010, 32'h86, 32'h0,
         1, -1, 3, 32'h00000001, 0, 32'h0);
`endif
      op("ld011", 0, 3'b011, 32'h80, 32'h0,
         -1, -1, 1, 32'h0, 1, 32'h0);
      op("ld110", 0, 3'b110, 32'h84, 32'h0,
         -1, -1, 1, 32'h0, 1, 32'h0);
      op("st100", 1, 3'b100, 32'h84, 32'h12345678,
         -1, -1, 1, 32'h0, 1, 32'h0);
      op("lw84b", 0, 3'b010, 32'h84, 32'h0,
         1, -1, 3, 32'h00000001, 0, 32'h0);

      // Reset during WAIT of an SB abandons the store
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
      req_addr = 32'h8C; req_wdata = 32'h55;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      seen = 0;
      if (mem_wr || resp_valid) seen++;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rstmid.ready", 32'(req_ready), 32'd1);
      for (int c = 0; c < 5; c++) begin
         if (mem_wr || resp_valid) seen++;
         @(posedge clk); #1;
      end
      chk("rstmid.no_wr_resp", 32'(seen), 32'd0);
      op("lw8c", 0, 3'b010, 32'h8C, 32'h0,
         1, -1, 3, 32'h00000002, 0, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
